transfer_sender: RTL

//  Serial transmitter for the transfer-center link: emits one bit per clk, MSB first, in back-to-back 8-bit frames.

---
 rtl/transfer_sender.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/transfer_sender.sv
// ---------------------------------------------------------------------------
// transfer_sender
//
// Serial transmitter for the transfer-center link. One bit leaves on every
// clk, MSB first, in back-to-back 8-bit frames that are aligned to a
// free-running 3-bit bit counter. At each frame boundary (bit_cnt == 7)
// exactly one byte source wins and its byte is loaded into the shift
// register; its MSB appears on dataOut in the following cycle.
//
// Byte sources, highest priority first:
//   1. the data byte still owed by a packet whose code frame is on the wire
//   2. a pending buffer-status code (1..4) derived from fill_level bands
//   3. a single-byte command (5 = flush, 6 = ready?)
//   4. a data packet: code 7 (binary) or 8 (ASCII), then the payload byte;
//      only started while peer_ready is high
//   5. the idle byte 8'h00
//
// Ports
//   clk          system clock, all logic on the rising edge
//   rst          synchronous active-low reset
//   fill_level   local buffer occupancy, compared against the band thresholds
//   cmd_valid    command request; cmd_code carries the command byte
//   cmd_ready    combinational; high at bit_cnt==7 when the command wins
//   cmd_err      one-cycle pulse after an illegal command code was dropped
//   data_valid   data packet request; data_byte / data_ascii are its payload
//   data_ready   combinational; high at bit_cnt==7 when the packet wins
//   peer_ready   far end ready; gates the start of data packets only
//   dataOut      serial bit (MSB of the shift register)
//   frame_start  high while dataOut carries bit 7 of a frame
//   busy         high while a non-idle frame (code or data) is on the wire
// ---------------------------------------------------------------------------
module transfer_sender #(
    parameter int unsigned LEVEL_W = 9,
    parameter int unsigned FULL    = 256,
    parameter int unsigned TH50    = 128,
    parameter int unsigned TH80    = 204,
    parameter int unsigned TH90    = 230
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LEVEL_W-1:0] fill_level,
    input  logic               cmd_valid,
    input  logic [7:0]         cmd_code,
    output logic               cmd_ready,
    output logic               cmd_err,
    input  logic               data_valid,
    input  logic [7:0]         data_byte,
    input  logic               data_ascii,
    output logic               data_ready,
    input  logic               peer_ready,
    output logic               dataOut,
    output logic               frame_start,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CODE = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam int unsigned N_TH = 4;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0] bit_cnt_reg;
    logic [7:0] shreg_reg;
    state_t     state_reg;
    logic       owe_data_reg;    // code 7/8 on the wire, payload goes next
    logic [7:0] data_hold_reg;   // payload captured at packet acceptance
    logic [2:0] band_reg;
    logic       pend_valid_reg;
    logic [2:0] pend_code_reg;
    logic       cmd_err_reg;

    // ------------------------------------------------------------------
    // Status band: the thresholds are increasing, so the band is simply
    // the number of thresholds the fill level has reached.
    // ------------------------------------------------------------------
    logic [N_TH-1:0] above;
    logic [2:0]      band_now;

    genvar gi;
    generate
        for (gi = 0; gi < N_TH; gi++) begin : g_th
            localparam int unsigned TH = (gi == 0) ? TH50 :
                                         (gi == 1) ? TH80 :
                                         (gi == 2) ? TH90 : FULL;
            assign above[gi] = (fill_level >= LEVEL_W'(TH));
        end
    endgenerate

    always_comb begin
        band_now = 3'd0;
        for (int i = 0; i < N_TH; i++) begin
            band_now = band_now + {2'b00, above[i]};
        end
    end

    logic band_rise;
    assign band_rise = (band_now > band_reg);

    // ------------------------------------------------------------------
    // Boundary arbitration
    // ------------------------------------------------------------------
    logic boundary;
    logic sel_owed;
    logic sel_stat;
    logic sel_cmd;
    logic sel_data;
    logic cmd_legal;

    assign boundary  = (bit_cnt_reg == 3'd7);
    assign sel_owed  = boundary & owe_data_reg;
    assign sel_stat  = boundary & ~owe_data_reg & pend_valid_reg;
    assign sel_cmd   = boundary & ~owe_data_reg & ~pend_valid_reg & cmd_valid;
    assign sel_data  = boundary & ~owe_data_reg & ~pend_valid_reg & ~cmd_valid
                       & data_valid & peer_ready;
    assign cmd_legal = (cmd_code == 8'd5) || (cmd_code == 8'd6);

    assign cmd_ready  = sel_cmd;
    assign data_ready = sel_data;

    logic [7:0] load_byte;
    state_t     load_state;

    always_comb begin
        load_byte  = 8'h00;
        load_state = IDLE;
        if (sel_owed) begin
            load_byte  = data_hold_reg;
            load_state = DATA;
        end else if (sel_stat) begin
            load_byte  = {5'b00000, pend_code_reg};
            load_state = CODE;
        end else if (sel_cmd) begin
            // An illegal command is consumed but replaced by the idle byte.
            if (cmd_legal) begin
                load_byte  = cmd_code;
                load_state = CODE;
            end
        end else if (sel_data) begin
            load_byte  = data_ascii ? 8'd8 : 8'd7;
            load_state = CODE;
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            bit_cnt_reg    <= 3'd0;
            shreg_reg      <= 8'h00;
            state_reg      <= IDLE;
            owe_data_reg   <= 1'b0;
            data_hold_reg  <= 8'h00;
            band_reg       <= 3'd0;
            pend_valid_reg <= 1'b0;
            pend_code_reg  <= 3'd0;
            cmd_err_reg    <= 1'b0;
        end else begin
            bit_cnt_reg <= bit_cnt_reg + 3'd1;

            if (boundary) begin
                shreg_reg    <= load_byte;
                state_reg    <= load_state;
                owe_data_reg <= sel_data;
                if (sel_data) begin
                    data_hold_reg <= data_byte;
                end
            end else begin
                shreg_reg <= {shreg_reg[6:0], 1'b0};
            end

            // Band tracks the fill level every cycle; only a rise queues a
            // code. A rise in the same cycle the old pending code is loaded
            // wins over the clear, so the new code stays pending.
            band_reg <= band_now;
            if (band_rise) begin
                pend_valid_reg <= 1'b1;
                pend_code_reg  <= band_now;
            end else if (sel_stat) begin
                pend_valid_reg <= 1'b0;
            end

            cmd_err_reg <= sel_cmd & ~cmd_legal;
        end
    end

    assign dataOut     = shreg_reg[7];
    assign frame_start = (bit_cnt_reg == 3'd0);
    assign busy        = (state_reg != IDLE);
    assign cmd_err     = cmd_err_reg;

endmodule
